// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the traffic phase scheduler:
//               direction and phase encodings, lane/sum widths and a helper
//               that maps a direction onto its two lane bits.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 8;
    localparam int SUM_W     = 9;
    localparam int NUM_DIRS  = 4;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } phase_t;

    // Direction d owns lanes 2d and 2d+1.
    function automatic logic [NUM_LANES-1:0] dir_lane_mask(input dir_t d);
        dir_lane_mask = 8'b0000_0011 << {d, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_max_select.sv
`default_nettype none
// ============================================================================
// Module      : lane_max_select
// Description : Combinational argmax over the four direction sums. A strict
//               greater-than scan from index 0 upward means ties (including
//               all-zero) resolve to the lowest index.
// Ports       : sums   - four SUM_W-bit direction sums (N, E, S, W)
//               winner - index of the largest sum
// Revision    : 1.0 - initial release
// ============================================================================
module lane_max_select
    import traffic_pkg::*;
(
    input  logic [NUM_DIRS-1:0][SUM_W-1:0] sums,
    output dir_t                           winner
);

    logic [SUM_W-1:0] w_best;

    always_comb begin
        winner = DIR_N;
        w_best = sums[0];
        for (int d = 1; d < NUM_DIRS; d++) begin
            if (sums[d] > w_best) begin
                w_best = sums[d];
                winner = dir_t'(2'(d));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Timed ALL_RED -> GREEN -> YELLOW phase controller. The green
//               direction is the one whose two lanes sum highest (lowest
//               index on ties). Enforces minimum/maximum green, yellow and
//               all-red clearance, and mid-green preemption.
//               Optional macro STARVE_GUARD_EN adds per-direction skip
//               counters that force a repeatedly passed-over direction.
// Ports       : clk           - system clock, rising edge
//               rst           - asynchronous active-high reset
//               lane          - per-lane car counts N1,N2,E1,E2,S1,S2,W1,W2
//               green_lights  - green per lane (registered)
//               yellow_lights - yellow per lane (registered)
//               all_red       - high while in ALL_RED (registered)
//               cur_dir       - current/last granted direction
//               phase_start   - one-cycle pulse on the first GREEN cycle
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN    = 8,
    parameter int GREEN_MAX    = 32,
    parameter int YELLOW_CYC   = 4,
    parameter int ALLRED_CYC   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]   lane,
    output logic [NUM_LANES-1:0]               green_lights,
    output logic [NUM_LANES-1:0]               yellow_lights,
    output logic                               all_red,
    output logic [1:0]                         cur_dir,
    output logic                               phase_start
);

    // Timer must hold the largest terminal count of any phase.
    localparam int c_TMAX    = (GREEN_MAX > YELLOW_CYC)
                             ? ((GREEN_MAX > ALLRED_CYC) ? GREEN_MAX : ALLRED_CYC)
                             : ((YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC);
    localparam int c_TIMER_W = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TIMER_W-1:0] c_ALLRED_END = c_TIMER_W'(ALLRED_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_YELLOW_END = c_TIMER_W'(YELLOW_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_GMIN_END   = c_TIMER_W'(GREEN_MIN - 1);
    localparam logic [c_TIMER_W-1:0] c_GMAX_END   = c_TIMER_W'(GREEN_MAX - 1);

    phase_t                        r_state;
    phase_t                        w_next_state;
    logic [c_TIMER_W-1:0]          r_timer;
    logic [c_TIMER_W-1:0]          w_next_timer;
    dir_t                          r_dir;
    dir_t                          w_next_dir;
    logic                          w_grant;

    logic [NUM_DIRS-1:0][SUM_W-1:0] w_sum;
    dir_t                          w_argmax;
    dir_t                          w_winner;
    logic                          w_starve_req;
    logic                          w_other_wait;
    logic                          w_other_higher;

    logic [NUM_LANES-1:0]          w_nx_green;
    logic [NUM_LANES-1:0]          w_nx_yellow;
    logic                          w_nx_all_red;

    // ------------------------------------------------------------------
    // Direction sums, 9 bits so two full lanes never overflow.
    // ------------------------------------------------------------------
    generate
        for (genvar d = 0; d < NUM_DIRS; d++) begin : g_sum
            assign w_sum[d] = {1'b0, lane[2*d]} + {1'b0, lane[2*d+1]};
        end
    endgenerate

    lane_max_select u_max (
        .sums   (w_sum),
        .winner (w_argmax)
    );

    // Demand from directions other than the one currently granted.
    always_comb begin
        w_other_wait   = 1'b0;
        w_other_higher = 1'b0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (2'(d) != r_dir) begin
                if (w_sum[d] != '0)
                    w_other_wait = 1'b1;
                if (w_sum[d] > w_sum[r_dir])
                    w_other_higher = 1'b1;
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int c_SKIP_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SKIP_W-1:0] c_SKIP_SAT = c_SKIP_W'(STARVE_LIMIT);

    logic [NUM_DIRS-1:0][c_SKIP_W-1:0] r_skip;
    logic [NUM_DIRS-1:0]               w_starved;

    always_comb begin
        for (int d = 0; d < NUM_DIRS; d++)
            w_starved[d] = (r_skip[d] == c_SKIP_SAT);
    end

    // A starved direction overrides the argmax; scanning downward leaves
    // the lowest-index starved direction as the winner.
    always_comb begin
        w_winner = w_argmax;
        for (int d = NUM_DIRS - 1; d >= 0; d--) begin
            if (w_starved[d])
                w_winner = dir_t'(2'(d));
        end
    end

    always_comb begin
        w_starve_req = 1'b0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (w_starved[d] && (2'(d) != r_dir))
                w_starve_req = 1'b1;
        end
    end

    // Skip counters only move at a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip <= '0;
        end else if (w_grant) begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                if ((2'(d) == w_winner) || (w_sum[d] == '0))
                    r_skip[d] <= '0;
                else if (r_skip[d] != c_SKIP_SAT)
                    r_skip[d] <= r_skip[d] + c_SKIP_W'(1);
            end
        end
    end
`else
    assign w_winner     = w_argmax;
    assign w_starve_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state, timer and next-output decode.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer + c_TIMER_W'(1);
        w_next_dir   = r_dir;
        w_grant      = 1'b0;

        case (r_state)
            ALL_RED: begin
                if (r_timer == c_ALLRED_END) begin
                    w_next_state = GREEN;
                    w_next_timer = '0;
                    w_next_dir   = w_winner;
                    w_grant      = 1'b1;
                end
            end
            GREEN: begin
                if (((r_timer >= c_GMIN_END) && (w_other_higher || w_starve_req)) ||
                    ((r_timer == c_GMAX_END) && w_other_wait)) begin
                    w_next_state = YELLOW;
                    w_next_timer = '0;
                end else if (r_timer == c_GMAX_END) begin
                    // Nobody else waiting: hold green with a saturated timer.
                    w_next_timer = r_timer;
                end
            end
            YELLOW: begin
                if (r_timer == c_YELLOW_END) begin
                    w_next_state = ALL_RED;
                    w_next_timer = '0;
                end
            end
            default: begin
                w_next_state = ALL_RED;
                w_next_timer = '0;
            end
        endcase

        w_nx_green   = (w_next_state == GREEN)  ? dir_lane_mask(w_next_dir) : '0;
        w_nx_yellow  = (w_next_state == YELLOW) ? dir_lane_mask(w_next_dir) : '0;
        w_nx_all_red = (w_next_state == ALL_RED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ALL_RED;
            r_timer       <= '0;
            r_dir         <= DIR_N;
            green_lights  <= '0;
            yellow_lights <= '0;
            all_red       <= 1'b1;
            phase_start   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_timer       <= w_next_timer;
            r_dir         <= w_next_dir;
            green_lights  <= w_nx_green;
            yellow_lights <= w_nx_yellow;
            all_red       <= w_nx_all_red;
            phase_start   <= w_grant;
        end
    end

    assign cur_dir = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Directed self-checking bench for traffic_phase_scheduler
//               with GREEN_MIN=3, GREEN_MAX=6, YELLOW_CYC=2, ALLRED_CYC=2,
//               STARVE_LIMIT=2. Honours STARVE_GUARD_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    logic             clk;
    logic             rst;
    logic [7:0][7:0]  lane;
    logic [7:0]       green_lights;
    logic [7:0]       yellow_lights;
    logic             all_red;
    logic [1:0]       cur_dir;
    logic             phase_start;

    int checks;
    int errors;

    traffic_phase_scheduler #(
        .GREEN_MIN    (3),
        .GREEN_MAX    (6),
        .YELLOW_CYC   (2),
        .ALLRED_CYC   (2),
        .STARVE_LIMIT (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lane          (lane),
        .green_lights  (green_lights),
        .yellow_lights (yellow_lights),
        .all_red       (all_red),
        .cur_dir       (cur_dir),
        .phase_start   (phase_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return the DUT is in its first ALL_RED cycle.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_hold();
        lane = '0;
        lane[2] = 8'd5;
        do_reset();
        checks++; if (green_lights !== 8'h00) begin errors++; $display("FAIL reset_green got=%b exp=%b", green_lights, 8'h00); end
        checks++; if (yellow_lights !== 8'h00) begin errors++; $display("FAIL reset_yellow got=%b exp=%b", yellow_lights, 8'h00); end
        checks++; if (all_red !== 1'b1) begin errors++; $display("FAIL reset_all_red got=%b exp=1", all_red); end
        checks++; if (cur_dir !== 2'd0) begin errors++; $display("FAIL reset_cur_dir got=%0d exp=0", cur_dir); end
        checks++; if (phase_start !== 1'b0) begin errors++; $display("FAIL reset_phase_start got=%b exp=0", phase_start); end
        tick();
        checks++; if (all_red !== 1'b1 || green_lights !== 8'h00) begin errors++; $display("FAIL allred_cyc2 all_red=%b green=%b exp 1/00000000", all_red, green_lights); end
        tick();
        checks++; if (green_lights !== 8'b0000_1100) begin errors++; $display("FAIL e_green got=%b exp=00001100", green_lights); end
        checks++; if (cur_dir !== 2'd1) begin errors++; $display("FAIL e_cur_dir got=%0d exp=1", cur_dir); end
        checks++; if (phase_start !== 1'b1) begin errors++; $display("FAIL e_phase_start got=%b exp=1", phase_start); end
        checks++; if (all_red !== 1'b0) begin errors++; $display("FAIL e_all_red got=%b exp=0", all_red); end
        tick();
        checks++; if (phase_start !== 1'b0) begin errors++; $display("FAIL e_pulse_once got=%b exp=0", phase_start); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (green_lights !== 8'b0000_1100 || yellow_lights !== 8'h00) begin
                errors++;
                $display("FAIL e_hold[%0d] green=%b yellow=%b exp 00001100/00000000", i, green_lights, yellow_lights);
            end
        end
    endtask

    task automatic test_preempt();
        lane = '0;
        lane[0] = 8'd10;
        do_reset();
        tick(); tick();
        checks++; if (green_lights !== 8'b0000_0011 || cur_dir !== 2'd0) begin errors++; $display("FAIL pre_n_green green=%b dir=%0d exp 00000011/0", green_lights, cur_dir); end
        tick();
        lane[7] = 8'd20;
        tick();
        checks++; if (green_lights !== 8'b0000_0011) begin errors++; $display("FAIL pre_min_hold green=%b exp=00000011", green_lights); end
        tick();
        checks++; if (yellow_lights !== 8'b0000_0011 || green_lights !== 8'h00) begin errors++; $display("FAIL pre_yellow1 yellow=%b green=%b exp 00000011/00000000", yellow_lights, green_lights); end
        tick();
        checks++; if (yellow_lights !== 8'b0000_0011) begin errors++; $display("FAIL pre_yellow2 yellow=%b exp=00000011", yellow_lights); end
        tick();
        checks++; if (all_red !== 1'b1 || yellow_lights !== 8'h00) begin errors++; $display("FAIL pre_allred1 all_red=%b yellow=%b exp 1/00000000", all_red, yellow_lights); end
        tick();
        checks++; if (all_red !== 1'b1) begin errors++; $display("FAIL pre_allred2 all_red=%b exp=1", all_red); end
        tick();
        checks++; if (green_lights !== 8'b1100_0000 || cur_dir !== 2'd3 || phase_start !== 1'b1) begin errors++; $display("FAIL pre_w_green green=%b dir=%0d ps=%b exp 11000000/3/1", green_lights, cur_dir, phase_start); end
    endtask

    task automatic test_max_green();
        lane = '0;
        lane[0] = 8'd4;
        lane[4] = 8'd3;
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (green_lights !== 8'b0000_0011) begin
                errors++;
                $display("FAIL max_green[%0d] got=%b exp=00000011", i, green_lights);
            end
        end
        tick();
        checks++; if (yellow_lights !== 8'b0000_0011 || green_lights !== 8'h00) begin errors++; $display("FAIL max_yellow yellow=%b green=%b exp 00000011/00000000", yellow_lights, green_lights); end
        lane[0] = 8'd0;
        tick(); tick(); tick(); tick();
        checks++; if (green_lights !== 8'b0011_0000 || cur_dir !== 2'd2) begin errors++; $display("FAIL max_s_green green=%b dir=%0d exp 00110000/2", green_lights, cur_dir); end
    endtask

    task automatic test_tie();
        lane = '0;
        lane[0] = 8'd7; lane[2] = 8'd7; lane[4] = 8'd7; lane[6] = 8'd7;
        do_reset();
        tick(); tick();
        checks++; if (green_lights !== 8'b0000_0011 || cur_dir !== 2'd0) begin errors++; $display("FAIL tie_all green=%b dir=%0d exp 00000011/0", green_lights, cur_dir); end
        lane = '0;
        lane[2] = 8'd9; lane[5] = 8'd9; lane[0] = 8'd1;
        do_reset();
        tick(); tick();
        checks++; if (green_lights !== 8'b0000_1100 || cur_dir !== 2'd1) begin errors++; $display("FAIL tie_es green=%b dir=%0d exp 00001100/1", green_lights, cur_dir); end
    endtask

    task automatic test_reset_in_yellow();
        lane = '0;
        lane[0] = 8'd10;
        do_reset();
        tick(); tick();
        lane[2] = 8'd20;
        tick(); tick(); tick();
        checks++; if (yellow_lights !== 8'b0000_0011) begin errors++; $display("FAIL ry_in_yellow got=%b exp=00000011", yellow_lights); end
        rst = 1'b1;
        #1;
        checks++; if (green_lights !== 8'h00 || yellow_lights !== 8'h00) begin errors++; $display("FAIL ry_lights_off green=%b yellow=%b exp 0/0", green_lights, yellow_lights); end
        checks++; if (all_red !== 1'b1 || cur_dir !== 2'd0) begin errors++; $display("FAIL ry_state all_red=%b dir=%0d exp 1/0", all_red, cur_dir); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(); tick();
        checks++; if (green_lights !== 8'b0000_1100 || phase_start !== 1'b1) begin errors++; $display("FAIL ry_restart green=%b ps=%b exp 00001100/1", green_lights, phase_start); end
    endtask

    task automatic test_starve();
        int s_seen;
        s_seen = 0;
        lane = '0;
        lane[2] = 8'd50;
        lane[4] = 8'd1;
        do_reset();
        tick(); tick();
        checks++; if (cur_dir !== 2'd1 || phase_start !== 1'b1) begin errors++; $display("FAIL st_grant1 dir=%0d ps=%b exp 1/1", cur_dir, phase_start); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (cur_dir !== 2'd1 || phase_start !== 1'b1) begin errors++; $display("FAIL st_grant2 dir=%0d ps=%b exp 1/1", cur_dir, phase_start); end
        for (int i = 0; i < 7; i++) tick();
`ifdef STARVE_GUARD_EN
        checks++; if (green_lights !== 8'b0011_0000 || cur_dir !== 2'd2) begin errors++; $display("FAIL st_s_forced green=%b dir=%0d exp 00110000/2", green_lights, cur_dir); end
`else
        checks++; if (yellow_lights !== 8'b0000_1100) begin errors++; $display("FAIL st_e_yellow yellow=%b exp=00001100", yellow_lights); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cur_dir == 2'd2) s_seen++;
            checks++;
            if ((green_lights != 8'h00) && (yellow_lights != 8'h00)) begin
                errors++;
                $display("FAIL st_safety[%0d] green=%b yellow=%b", i, green_lights, yellow_lights);
            end
        end
        checks++; if (s_seen !== 0) begin errors++; $display("FAIL st_s_never got=%0d cycles exp=0", s_seen); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        lane   = '0;
        test_reset_hold();
        test_preempt();
        test_max_green();
        test_tie();
        test_reset_in_yellow();
        test_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
